// File: rtl/alu_sched_pkg.sv
// alu_sched_pkg: state, op and requester constants plus a one-hot helper shared by the scheduler files
package alu_sched_pkg;
  localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2;
  localparam logic OP_ADD = 1'b0, OP_LDH = 1'b1;
  localparam logic REQ0 = 1'b0, REQ1 = 1'b1;
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/alu_scheduler_if.sv
// alu_scheduler_if: request/ALU/response bundle; slave = scheduler side, master = requesters+ALU side
interface alu_scheduler_if #(parameter int WIDTH = 16);
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
  logic req0_op, req1_op, alu_op, alu_update, busy;
  logic [15:0] ops_done;
  modport slave (
    input req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_op, alu_update, rsp_valid, rsp_result, busy, ops_done
  );
  modport master (
    output req_valid, req0_a, req0_b, req0_op, req1_a, req1_b, req1_op, alu_result, rsp_ready,
    input req_ready, alu_a, alu_b, alu_op, alu_update, rsp_valid, rsp_result, busy, ops_done
  );
endinterface

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: two-way round-robin pick; i_req/i_last_grant in, one-hot o_grant and o_grant_idx out
module rr_arbiter2
  import alu_sched_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last_grant,
  output logic [1:0] o_grant,
  output logic       o_grant_idx
);
  assign o_grant_idx = &i_req ? ~i_last_grant : i_req[1];
  assign o_grant = |i_req ? onehot2(o_grant_idx) : 2'b00;
endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler: shares one ALU between two requesters (IDLE->EXEC->RESP); ports clk, rst, bus (alu_scheduler_if.slave)
module alu_scheduler
  import alu_sched_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic clk,
  input logic rst,
  alu_scheduler_if.slave bus
);
  logic [1:0] r_state, r_rsp_valid, w_grant;
  logic r_last, r_owner, r_alu_op, w_idx, w_accept, w_done;
  logic [WIDTH-1:0] r_alu_a, r_alu_b, r_result;
  logic [15:0] r_ops;
  rr_arbiter2 u_arb (
    .i_req(bus.req_valid),
    .i_last_grant(r_last),
    .o_grant(w_grant),
    .o_grant_idx(w_idx)
  );
  assign w_accept = r_state == IDLE && |bus.req_valid;
  assign w_done = r_state == RESP && bus.rsp_ready[r_owner];
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_last <= REQ1;
      r_owner <= REQ0;
      r_alu_a <= '0;
      r_alu_b <= '0;
      r_alu_op <= OP_ADD;
      r_rsp_valid <= 2'b00;
      r_result <= '0;
      r_ops <= '0;
    end else if (w_accept) begin
      r_alu_a <= w_idx ? bus.req1_a : bus.req0_a;
      r_alu_b <= w_idx ? bus.req1_b : bus.req0_b;
      r_alu_op <= w_idx ? bus.req1_op : bus.req0_op;
      r_owner <= w_idx;
      r_state <= EXEC;
    end else if (r_state == EXEC) begin
      r_result <= bus.alu_result;
      r_rsp_valid <= onehot2(r_owner);
      r_state <= RESP;
    end else if (w_done) begin
      r_rsp_valid <= 2'b00;
      r_last <= r_owner;
      r_ops <= r_ops + {15'd0, ~&r_ops};
      r_state <= IDLE;
    end
  end
  assign bus.req_ready = r_state == IDLE ? w_grant : 2'b00;
  assign bus.alu_a = r_alu_a;
  assign bus.alu_b = r_alu_b;
  assign bus.alu_op = r_alu_op;
  assign bus.alu_update = r_state == EXEC;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_result = r_result;
  assign bus.busy = r_state != IDLE;
  assign bus.ops_done = r_ops;
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed vector table plus contention, backpressure and reset sequences for alu_scheduler
module tb_alu_scheduler;
  import alu_sched_pkg::*;
  typedef struct {
    logic req;
    logic [15:0] a, b;
    logic op;
    logic [15:0] exp;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int ops = 0;
  vec_t vecs[6];
  alu_scheduler_if #(.WIDTH(16)) bus ();
  alu_scheduler #(.WIDTH(16)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  assign bus.alu_result = bus.alu_op ? {bus.alu_b[7:0], 8'h00} : bus.alu_a + bus.alu_b;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic wait_grant(output logic [1:0] g);
    g = 2'b00;
    for (int i = 0; i < 20 && g == 2'b00; i++) begin
      #1;
      g = bus.req_ready;
      if (g == 2'b00) @(negedge clk);
    end
  endtask
  task automatic set_req(input logic req, input logic [15:0] a, input logic [15:0] b, input logic op);
    if (req) begin
      bus.req1_a = a;
      bus.req1_b = b;
      bus.req1_op = op;
    end else begin
      bus.req0_a = a;
      bus.req0_b = b;
      bus.req0_op = op;
    end
  endtask
  task automatic do_op(input logic req, input logic [15:0] a, input logic [15:0] b, input logic op,
                       input logic [15:0] exp);
    logic [1:0] g, oh;
    oh = onehot2(req);
    @(negedge clk);
    set_req(req, a, b, op);
    bus.req_valid = oh;
    wait_grant(g);
    check("grant", g, oh);
    @(negedge clk);
    bus.req_valid = 2'b00;
    set_req(req, ~a, ~b, ~op);
    check("update_n1", bus.alu_update, 1);
    check("busy_n1", bus.busy, 1);
    check("alu_a", bus.alu_a, a);
    check("alu_b", bus.alu_b, b);
    check("alu_op", bus.alu_op, op);
    @(negedge clk);
    check("update_n2", bus.alu_update, 0);
    check("rsp_valid", bus.rsp_valid, oh);
    check("rsp_result", bus.rsp_result, exp);
    bus.rsp_ready = oh;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    ops++;
    check("rsp_cleared", bus.rsp_valid, 0);
    check("busy_idle", bus.busy, 0);
    check("ops_done", bus.ops_done, ops);
  endtask
  initial begin
    logic [1:0] g, eg;
    vecs[0] = '{1'b0, 16'h1234, 16'h0F0F, OP_ADD, 16'h2143};
    vecs[1] = '{1'b1, 16'hFFFF, 16'h0002, OP_ADD, 16'h0001};
    vecs[2] = '{1'b0, 16'h5555, 16'hABCD, OP_LDH, 16'hCD00};
    vecs[3] = '{1'b1, 16'h0000, 16'h00FF, OP_LDH, 16'hFF00};
    vecs[4] = '{1'b0, 16'h8000, 16'h8000, OP_ADD, 16'h0000};
    vecs[5] = '{1'b1, 16'h0001, 16'h0001, OP_ADD, 16'h0002};
    bus.req_valid = 2'b00;
    bus.rsp_ready = 2'b00;
    set_req(1'b0, 16'h0, 16'h0, OP_ADD);
    set_req(1'b1, 16'h0, 16'h0, OP_ADD);
    @(negedge clk);
    #1;
    check("rst_ready", bus.req_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_ops", bus.ops_done, 0);
    check("rst_rsp", bus.rsp_valid, 0);
    check("rst_result", bus.rsp_result, 0);
    check("rst_alu", {bus.alu_a, bus.alu_b}, 0);
    check("rst_upd", {bus.alu_update, bus.alu_op}, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) do_op(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
    @(negedge clk);
    set_req(1'b0, 16'h4444, 16'h1111, OP_ADD);
    bus.req_valid = 2'b01;
    wait_grant(g);
    check("mid_grant", g, 2'b01);
    @(negedge clk);
    bus.req_valid = 2'b00;
    check("mid_update", bus.alu_update, 1);
    rst = 1'b1;
    ops = 0;
    #1;
    check("mid_rst_upd", bus.alu_update, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ops", bus.ops_done, 0);
    check("mid_rst_alu_a", bus.alu_a, 0);
    check("mid_rst_rsp", {bus.rsp_valid, bus.rsp_result}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    set_req(1'b0, 16'h0001, 16'h0002, OP_ADD);
    set_req(1'b1, 16'h0000, 16'h0012, OP_LDH);
    bus.req_valid = 2'b11;
    bus.rsp_ready = 2'b11;
    for (int k = 0; k < 4; k++) begin
      eg = onehot2(k[0]);
      wait_grant(g);
      check("rr_grant", g, eg);
      @(negedge clk);
      if (k == 3) bus.req_valid = 2'b00;
      check("rr_update", bus.alu_update, 1);
      @(negedge clk);
      check("rr_rsp_valid", bus.rsp_valid, eg);
      check("rr_result", bus.rsp_result, k[0] ? 16'h1200 : 16'h0003);
      ops++;
      @(negedge clk);
    end
    bus.rsp_ready = 2'b00;
    check("rr_ops4", bus.ops_done, 4);
    set_req(1'b1, 16'h0100, 16'h0023, OP_ADD);
    bus.req_valid = 2'b10;
    wait_grant(g);
    check("bp_grant1", g, 2'b10);
    @(negedge clk);
    set_req(1'b0, 16'h0007, 16'h0008, OP_ADD);
    bus.req_valid = 2'b01;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      #1;
      check("bp_ready0", bus.req_ready, 0);
      check("bp_hold", bus.rsp_result, 16'h0123);
      check("bp_valid", bus.rsp_valid, 2'b10);
      if (i >= 5) bus.rsp_ready = 2'b01;
      @(negedge clk);
    end
    check("wrong_owner_busy", bus.busy, 1);
    bus.rsp_ready = 2'b10;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    ops++;
    #1;
    check("bp_next_grant", bus.req_ready, 2'b01);
    check("bp_cleared", bus.rsp_valid, 0);
    check("bp_ops", bus.ops_done, ops);
    @(negedge clk);
    bus.req_valid = 2'b00;
    check("bp_update", bus.alu_update, 1);
    check("bp_alu_a", bus.alu_a, 16'h0007);
    @(negedge clk);
    check("bp_rsp0", bus.rsp_valid, 2'b01);
    check("bp_result0", bus.rsp_result, 16'h000F);
    bus.rsp_ready = 2'b01;
    @(negedge clk);
    bus.rsp_ready = 2'b00;
    ops++;
    check("bp_ops_final", bus.ops_done, ops);
    check("bp_idle", bus.busy, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_scheduler.md
# alu_scheduler

Two-requester scheduler that shares the single 16-bit ALU (ADD / load-high-byte) between the instruction-execute path (requester 0) and the address/immediate path (requester 1). It accepts one operation at a time through a valid/ready handshake, arbitrates round-robin, drives the ALU operands and op select, registers the result, and holds it until the owning requester takes it. It sits between the control unit and the ALU and sequences the ALU's update strobe.

## Interface
Parameters:
- WIDTH, 16, operand/result width (ALU is fixed 16; other values are unsupported)

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_ready  out  2  per-requester accept; one-hot or zero
- req0_a, req0_b  in  WIDTH each  requester 0 operands
- req0_op  in  1  requester 0 op: 0 = ADD, 1 = LDH
- req1_a, req1_b  in  WIDTH each  requester 1 operands
- req1_op  in  1  requester 1 op
- alu_a, alu_b  out  WIDTH each  registered ALU operands
- alu_op  out  1  registered ALU op select
- alu_update  out  1  one-cycle strobe while ALU is evaluated (to ALU_update_flag)
- alu_result  in  WIDTH  combinational ALU result
- rsp_valid  out  2  per-requester response valid; one-hot or zero
- rsp_ready  in  2  per-requester response accept
- rsp_result  out  WIDTH  registered result, shared by both requesters
- busy  out  1  high in any state except IDLE
- ops_done  out  16  count of completed responses, saturates at 16'hFFFF

## Operation
- States: IDLE, EXEC, RESP.
- IDLE: if any req_valid, grant = requester not equal to last_grant when both valid, else the single valid one. req_ready[grant] = 1 combinationally in IDLE only. On that cycle latch grant's a/b/op into alu_a/alu_b/alu_op, owner <= grant, go EXEC.
- EXEC: alu_update = 1; capture alu_result into rsp_result; rsp_valid[owner] <= 1; go RESP.
- RESP: hold rsp_result and rsp_valid until rsp_ready[owner]. On handshake: clear rsp_valid, last_grant <= owner, ops_done += 1 (unless saturated), go IDLE. rsp_ready of the non-owner is ignored.
- Ops: ADD = (a + b) mod 2^16, carry discarded; LDH = {b[7:0], 8'h00}, a ignored. Computation is in the ALU; the scheduler never modifies the result.
- Requesters hold req_valid and operands until req_ready; operands are sampled only on the accept cycle; later changes have no effect.
- Withdrawn valid before accept: no grant, no state change.
- Response never accepted: scheduler stalls in RESP indefinitely; no new request accepted, both req_ready = 0.
- Reset (any state, asynchronous): state IDLE, last_grant = 1 (requester 0 wins first tie), owner = 0, all outputs 0 (req_ready, alu_a/b/op, alu_update, rsp_valid, rsp_result, busy, ops_done). An in-flight operation is discarded.

## Timing
- Accept at cycle N (req_ready & req_valid), alu_update high cycle N+1, rsp_valid high from N+2.
- Earliest next accept: the cycle after the response handshake; minimum 3 cycles per operation.
- req_ready is combinational from req_valid and state; all other outputs are registered.
- busy high from N+1 through the handshake cycle.

## Structure
- Package alu_sched_pkg: state enum (IDLE, EXEC, RESP), op constants OP_ADD = 1'b0, OP_LDH = 1'b1, requester index constants.
- Sub-module rr_arbiter2: inputs req[1:0], last_grant; outputs one-hot grant and grant index; purely combinational.

## Test plan
- Reset: assert rst mid-EXEC -> next sampled outputs all 0, busy = 0, ops_done = 0; first request after release accepted normally.
- Single ADD: requester 0, a = 16'h1234, b = 16'h0F0F -> req_ready[0] at N, alu_update at N+1, rsp_valid[0] with rsp_result = 16'h2143 at N+2.
- Overflow and LDH: ADD 16'hFFFF + 16'h0002 -> 16'h0001; LDH b = 16'hABCD -> 16'hCD00.
- Contention: both valid from reset continuously -> grants alternate 0,1,0,1 for four operations; ops_done = 4.
- Backpressure: hold rsp_ready[1] = 0 for 10 cycles with req_valid[0] = 1 -> rsp_result stable, req_ready = 0 throughout; requester 0 accepted the cycle after rsp_ready[1] handshake.
- Wrong-owner ready: rsp_ready[0] = 1 while requester 1 owns -> no handshake, state stays RESP.
